sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two readdata words. On a start request (or automatically after reset), it reads word 0 (system ID) and word 1 (build timestamp), captures both, and compares them against build-time expected values. It reports pass/fail and per-word match flags to the bring-up status logic. A timeout flags a hung or absent slave.

## Interface

Parameters:
- EXPECTED_ID, 32'hACD51302, expected word 0 (system ID).
- EXPECTED_TIMESTAMP, 32'h52E1ECE9, expected word 1 (timestamp).
- TIMEOUT, 255, maximum consecutive waitrequest cycles per read, range 1..65535.
- AUTO_START, 1, when 1 a check launches automatically after reset release.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clock, input, 1, single clock domain; all state updates on rising edge.
  - reset, input, 1, asynchronous, active-high.
- Control:
  - start, input, 1, one-cycle check request, sampled only in IDLE.
- Avalon-MM master:
  - avm_address, output, 1, 0 selects the ID word, 1 selects the timestamp word.
  - avm_read, output, 1, read strobe.
  - avm_waitrequest, input, 1, slave stall.
  - avm_readdata, input, 32, read data, valid when avm_read && !avm_waitrequest (zero latency).
- Status:
  - busy, output, 1, high from start acceptance until done.
  - done, output, 1, one-cycle pulse at check completion.
  - pass, output, 1, id_match && ts_match && !timeout_err, valid from done.
  - id_match, output, 1, captured ID equals EXPECTED_ID.
  - ts_match, output, 1, captured timestamp equals EXPECTED_TIMESTAMP.
  - timeout_err, output, 1, a read exceeded TIMEOUT.
  - id_value, output, 32, captured word 0.
  - ts_value, output, 32, captured word 1.

## Operation

- Reset values:
  - All outputs are 0; id_value and ts_value are 0.
  - State is IDLE and the timeout counter is 0.
- State machine:
  - IDLE:
    - Moves to RD_ID when start=1, or on the first edge after reset release if AUTO_START=1.
    - On this transition, pass, id_match, ts_match and timeout_err clear to 0, and busy goes to 1.
  - RD_ID:
    - avm_read=1, avm_address=0.
    - When avm_waitrequest=0, id_value is loaded from avm_readdata and the state moves to RD_TS; the counter clears.
  - RD_TS:
    - avm_read=1, avm_address=1.
    - When avm_waitrequest=0, ts_value is loaded and the state moves to IDLE.
    - On the same edge: done=1 for one cycle, busy=0, and the match flags and pass are updated from the captured words (use the incoming readdata for the ts compare).
  - Timeout, in RD_ID or RD_TS:
    - The 16-bit counter increments on each cycle with avm_waitrequest=1.
    - When the counter equals TIMEOUT and waitrequest is still 1, the state moves to IDLE with avm_read=0, timeout_err=1, done pulse, busy=0 and pass=0.
    - The match flags for unread words stay 0; words already captured are retained.
- avm_read and avm_address are registered outputs that are decoded from state only. avm_address is 0 whenever avm_read=0.
- start while busy is ignored; no queuing.
- Results (flags and values) hold until the next accepted start.
- A reset asserted mid-check aborts immediately:
  - All outputs return to reset values asynchronously.
  - No done pulse is produced.
  - With AUTO_START=1, a fresh check launches after release.

## Timing

- With waitrequest held 0 and start sampled at edge N:
  - RD_ID is active (avm_read=1, addr 0) after N.
  - ID captured at N+1; RD_TS active after N+1.
  - Timestamp captured at N+2; done, pass, id_match and ts_match are valid in the cycle after N+2.
  - busy is high for exactly 2 cycles.
- Each cycle of waitrequest on a read adds one cycle of latency.
- Timeout fires TIMEOUT cycles after the read is first asserted with continuous waitrequest. Worst-case busy is 2*TIMEOUT cycles.
- A start on the same cycle that done is high is ignored, because the state is not yet IDLE at that edge. A start on the following cycle is accepted.

## Test plan

- Auto start, matching slave (word 0 = 0xACD51302, word 1 = 0x52E1ECE9, no wait): done rises 3 cycles after reset release; pass=1, id_match=1, ts_match=1; id_value and ts_value equal the slave words.
- Timestamp mismatch (word 1 = 0x52E1ECE8), AUTO_START=0, start pulse: done after 3 cycles; id_match=1, ts_match=0, pass=0, ts_value=0x52E1ECE8.
- Waitrequest of 3 cycles on each read: ID captured on the 4th RD_ID cycle; done 9 cycles after start; pass=1.
- Hung slave (waitrequest stuck 1, TIMEOUT=8): avm_read drops after 8 cycles at address 0; timeout_err=1, pass=0, id_match=0; done is a single pulse.
- start pulses while busy and on the done cycle: no extra read transactions; a start one cycle later launches exactly one new check, and the flags clear on acceptance.
- Reset asserted during RD_TS: all outputs are 0 immediately and there is no done pulse; with AUTO_START=1, a full check completes after release with pass=1.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system-ID word and the
// build-timestamp word, then compares both against build-time expected values.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h52E1ECE9,
  parameter int unsigned TIMEOUT            = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        auto_q, auto_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  always_comb begin
    // NOTE: every _d starts from its _q (done from 0) so no branch can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    auto_d     = auto_q;
    read_d     = read_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    cnt_inc    = cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        // The auto-launch request is consumed on the first edge after reset.
        auto_d = 1'b0;
        if (start || auto_q) begin
          state_d    = RD_ID;
          read_d     = 1'b1;
          addr_d     = 1'b0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
          timeout_d  = 1'b0;
          cnt_d      = 16'd0;
        end
      end

      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          state_d    = RD_TS;
          addr_d     = 1'b1;
          cnt_d      = 16'd0;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_d   = IDLE;
          read_d    = 1'b0;
          addr_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          // Compare the timestamp straight off the bus; ts_value_q is not loaded yet.
          ts_value_d = avm_readdata;
          state_d    = IDLE;
          read_d     = 1'b0;
          addr_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          id_match_d = (id_value_q == EXPECTED_ID);
          ts_match_d = (avm_readdata == EXPECTED_TIMESTAMP);
          pass_d     = (id_value_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
          cnt_d      = 16'd0;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_d    = IDLE;
          read_d     = 1'b0;
          addr_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          id_match_d = (id_value_q == EXPECTED_ID);
          cnt_d      = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        addr_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      auto_q     <= AUTO_START;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a behavioural system-ID slave with programmable wait
// states, plus a scoreboard of expected check results popped on each done pulse.
module tb_sysid_checker;

  localparam logic [31:0] ID_OK  = 32'hACD51302;
  localparam logic [31:0] TS_OK  = 32'h52E1ECE9;
  localparam logic [31:0] TS_BAD = 32'h52E1ECE8;
  localparam int          TMO    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start_man = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = ID_OK;
  logic        busy, done, pass, id_match, ts_match, timeout_err;
  logic [31:0] id_value, ts_value;

  logic        m_addr, m_read, m_busy, m_done, m_pass, m_idm, m_tsm, m_tmo;
  logic [31:0] m_idv, m_tsv;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int done_count = 0;
  int reads_accepted = 0;
  int read_cycles = 0;
  int busy_cycles = 0;
  bit addr1_seen = 1'b0;

  int          slave_wait = 0;
  int          wait_left = 0;
  logic        prev_read = 1'b0;
  logic        prev_addr = 1'b0;
  logic [31:0] slave_w0 = ID_OK;
  logic [31:0] slave_w1 = TS_OK;

  // flags = {pass, id_match, ts_match, timeout_err}
  typedef struct {
    logic [3:0]  flags;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    int          done_edge;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  sysid_checker #(
    .EXPECTED_ID(ID_OK), .EXPECTED_TIMESTAMP(TS_OK), .TIMEOUT(TMO), .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .pass(pass), .id_match(id_match), .ts_match(ts_match),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  // Second instance with auto-launch disabled; it must stay idle with start low.
  sysid_checker #(
    .EXPECTED_ID(ID_OK), .EXPECTED_TIMESTAMP(TS_OK), .TIMEOUT(TMO), .AUTO_START(1'b0)
  ) u_dut_man (
    .clock(clock), .reset(reset), .start(start_man),
    .avm_address(m_addr), .avm_read(m_read),
    .avm_waitrequest(1'b0), .avm_readdata(avm_readdata),
    .busy(m_busy), .done(m_done), .pass(m_pass), .id_match(m_idm), .ts_match(m_tsm),
    .timeout_err(m_tmo), .id_value(m_idv), .ts_value(m_tsv)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt++;

  // Slave model and scoreboard monitor, evaluated mid-cycle.
  always @(negedge clock) begin
    if (avm_read && (!prev_read || avm_address != prev_addr)) wait_left = slave_wait;
    prev_read = avm_read;
    prev_addr = avm_address;
    avm_waitrequest = avm_read && (wait_left > 0);
    if (avm_waitrequest) wait_left--;
    avm_readdata = avm_address ? slave_w1 : slave_w0;
    if (avm_read && !avm_waitrequest) reads_accepted++;
    if (avm_read) read_cycles++;
    if (avm_read && avm_address) addr1_seen = 1'b1;
    if (busy) busy_cycles++;
    if (done) begin
      done_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at edge %0d, required no pending check", edge_cnt);
      end else begin
        got = sb.pop_front();
        checks++;
        if (edge_cnt != got.done_edge) begin
          errors++;
          $display("FAIL chk%0d done_edge: got %0d required %0d", got.tag, edge_cnt, got.done_edge);
        end
        checks++;
        if ({pass, id_match, ts_match, timeout_err} !== got.flags) begin
          errors++;
          $display("FAIL chk%0d flags{pass,id,ts,tmo}: got %b required %b", got.tag,
                   {pass, id_match, ts_match, timeout_err}, got.flags);
        end
        checks++;
        if (id_value !== got.id_v) begin
          errors++;
          $display("FAIL chk%0d id_value: got %h required %h", got.tag, id_value, got.id_v);
        end
        checks++;
        if (ts_value !== got.ts_v) begin
          errors++;
          $display("FAIL chk%0d ts_value: got %h required %h", got.tag, ts_value, got.ts_v);
        end
      end
    end
  end

  task automatic wait_done(input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (done_count > n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000000",
               {avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout_err});
    end
    checks++;
    if (id_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_id_value: got %h required 00000000", id_value);
    end
    checks++;
    if (ts_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_ts_value: got %h required 00000000", ts_value);
    end
  endtask

  task automatic test_auto_start();
    int e0, d0;
    bit ok;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({avm_read, busy} !== 2'b00) begin
      errors++;
      $display("FAIL in_reset_idle: read,busy got %b required 00", {avm_read, busy});
    end
    e0 = edge_cnt;
    d0 = done_count;
    sb.push_back('{4'b1110, ID_OK, TS_OK, e0 + 3, 1});
    busy_cycles = 0;
    reset = 1'b0;
    wait_done(d0, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL auto_start_done: no done within 20 cycles, required one");
    end
    checks++;
    if (busy_cycles != 2) begin
      errors++;
      $display("FAIL auto_busy_cycles: got %0d required 2", busy_cycles);
    end
    checks++;
    if ({m_read, m_addr, m_busy, m_done} !== 4'b0000) begin
      errors++;
      $display("FAIL manual_idle: read,addr,busy,done got %b required 0000",
               {m_read, m_addr, m_busy, m_done});
    end
  endtask

  task automatic test_ts_mismatch();
    int e0, d0;
    bit ok;
    slave_w1 = TS_BAD;
    @(posedge clock); #1;
    e0 = edge_cnt;
    d0 = done_count;
    sb.push_back('{4'b0100, ID_OK, TS_BAD, e0 + 3, 2});
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    // Previous result was a pass; acceptance must clear it.
    checks++;
    if ({busy, pass, id_match, ts_match} !== 4'b1000) begin
      errors++;
      $display("FAIL mismatch_accept: busy,pass,id,ts got %b required 1000",
               {busy, pass, id_match, ts_match});
    end
    wait_done(d0, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mismatch_done: no done within 20 cycles, required one");
    end
    slave_w1 = TS_OK;
  endtask

  task automatic test_wait_states();
    int e0, d0, r0;
    bit ok;
    slave_wait = 3;
    @(posedge clock); #1;
    e0 = edge_cnt;
    d0 = done_count;
    r0 = reads_accepted;
    sb.push_back('{4'b1110, ID_OK, TS_OK, e0 + 9, 3});
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({avm_read, avm_address} !== 2'b10) begin
      errors++;
      $display("FAIL wait_rd_id_hold: read,addr got %b required 10", {avm_read, avm_address});
    end
    @(posedge clock); #1;
    checks++;
    if ({avm_read, avm_address} !== 2'b11) begin
      errors++;
      $display("FAIL wait_rd_ts_entry: read,addr got %b required 11", {avm_read, avm_address});
    end
    wait_done(d0, 30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: no done within 30 cycles, required one");
    end
    checks++;
    if (reads_accepted - r0 != 2) begin
      errors++;
      $display("FAIL wait_reads: got %0d required 2", reads_accepted - r0);
    end
    slave_wait = 0;
  endtask

  task automatic test_timeout();
    int e0, d0, r0;
    bit ok;
    slave_wait = 1000;
    @(posedge clock); #1;
    e0 = edge_cnt;
    d0 = done_count;
    r0 = reads_accepted;
    read_cycles = 0;
    addr1_seen = 1'b0;
    // Captured words from the previous check are retained across the timeout.
    sb.push_back('{4'b0001, ID_OK, TS_OK, e0 + 1 + TMO, 4});
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(d0, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_done: no done within 40 cycles, required one");
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (read_cycles != TMO) begin
      errors++;
      $display("FAIL timeout_read_cycles: got %0d required %0d", read_cycles, TMO);
    end
    checks++;
    if (addr1_seen !== 1'b0) begin
      errors++;
      $display("FAIL timeout_addr: address 1 seen=%b required 0", addr1_seen);
    end
    checks++;
    if (reads_accepted != r0 || avm_read !== 1'b0) begin
      errors++;
      $display("FAIL timeout_bus: accepted %0d read=%b required 0 and 0", reads_accepted - r0, avm_read);
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL timeout_single_done: got %0d pulses required 1", done_count - d0);
    end
    slave_wait = 0;
  endtask

  task automatic test_back_to_back();
    int e0, d0, r0;
    bit ok;
    @(posedge clock); #1;
    e0 = edge_cnt;
    d0 = done_count;
    r0 = reads_accepted;
    sb.push_back('{4'b1110, ID_OK, TS_OK, e0 + 3, 5});
    // start stays high through both busy edges, including the completing edge.
    start = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b required 1", busy);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if ({done, pass} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_first_result: done,pass got %b required 11", {done, pass});
    end
    sb.push_back('{4'b1110, ID_OK, TS_OK, e0 + 6, 6});
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if ({busy, pass, done} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_reaccept: busy,pass,done got %b required 100", {busy, pass, done});
    end
    wait_done(d0 + 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_second_done: no done within 20 cycles, required one");
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (done_count - d0 != 2 || reads_accepted - r0 != 4) begin
      errors++;
      $display("FAIL b2b_counts: dones %0d reads %0d required 2 and 4",
               done_count - d0, reads_accepted - r0);
    end
  endtask

  task automatic test_reset_mid_check();
    int e1, d0;
    bit ok;
    slave_wait = 3;
    @(posedge clock); #1;
    d0 = done_count;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if ({avm_read, avm_address} !== 2'b11) begin
      errors++;
      $display("FAIL abort_in_rd_ts: read,addr got %b required 11", {avm_read, avm_address});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout_err} !== 8'h00) begin
      errors++;
      $display("FAIL abort_flags: got %b required 00000000",
               {avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout_err});
    end
    checks++;
    if (id_value !== 32'd0 || ts_value !== 32'd0) begin
      errors++;
      $display("FAIL abort_values: id %h ts %h required 00000000", id_value, ts_value);
    end
    slave_wait = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses required 0", done_count - d0);
    end
    e1 = edge_cnt;
    sb.push_back('{4'b1110, ID_OK, TS_OK, e1 + 3, 7});
    reset = 1'b0;
    wait_done(d0, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_relaunch: no done within 20 cycles, required one");
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid_check();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
